// File: rtl/mem_arbiter.sv
// Two-port main-memory arbiter: icache (read-only) and dcache (read/write).
// Define ARB_DPRIORITY_EN to make the data port win all ties.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t state;
  logic   seen_busy;
  logic   last_grant;
  logic   req_i;
  logic   req_d;
  logic   grant_i;
  logic   grant_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // last_grant: 1 = data port was served last
`ifdef ARB_DPRIORITY_EN
  assign grant_i = req_i & ~req_d;
`else
  assign grant_i = req_i & (~req_d | last_grant);
`endif
  assign grant_d = req_d & ~grant_i;

  assign i_busywait = req_i & ~RESET & (state != RESP_I);
  assign d_busywait = req_d & ~RESET & (state != RESP_D);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      seen_busy     <= 1'b0;
      last_grant    <= 1'b1;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_i) begin
            state       <= BUSY_I;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= i_address;
            last_grant  <= 1'b0;
            seen_busy   <= 1'b0;
          end else if (grant_d) begin
            state         <= BUSY_D;
            mem_read      <= ~d_write;
            mem_write     <= d_write;
            mem_address   <= d_address;
            mem_writedata <= d_writedata;
            last_grant    <= 1'b1;
            seen_busy     <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          // memory raises busywait only after it sees the strobe
          if (mem_busywait) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            if (mem_read) begin
              if (state == BUSY_I) begin
                i_readdata <= mem_readdata;
              end else begin
                d_readdata <= mem_readdata;
              end
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= (state == BUSY_I) ? RESP_I : RESP_D;
          end
        end
        RESP_I, RESP_D: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps then random traffic,
// checked every cycle against a transfer-timeline reference model.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
`ifdef ARB_DPRIORITY_EN
  localparam bit DPRI = 1'b1;
`else
  localparam bit DPRI = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address),
    .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  // memory: busy for mem_lat posedges after the strobe is seen
  logic [DW-1:0] mem_arr [64];
  int            mem_lat = 5;
  int            mcnt = 0;
  logic          mdone = 1'b0;

  assign mem_busywait = (mem_read | mem_write) & ~mdone;
  assign mem_readdata = mdone ? mem_arr[mem_address]
                              : ~mem_arr[mem_address];

  always @(posedge CLK) begin
    if (RESET) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else if (mem_read | mem_write) begin
      if (!mdone) begin
        if (mcnt == mem_lat - 1) begin
          mdone <= 1'b1;
          if (mem_write) mem_arr[mem_address] = mem_writedata;
        end
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: one transfer owner and its grant cycle
  logic [DW-1:0] ref_mem [64];
  int            cyc = 0;
  int            m_own = 0;
  int            m_tg = 0;
  logic          m_wr = 1'b0;
  logic          m_last = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd_i = '0;
  logic [DW-1:0] m_rd_d = '0;

  task automatic model_step();
    bit gi;
    bit gd;
    int pick;
    if (RESET) begin
      m_own = 0; m_wr = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; m_rd_i = '0; m_rd_d = '0;
    end else if (m_own != 0) begin
      if (cyc == m_tg + mem_lat && m_wr) ref_mem[m_addr] = m_wdata;
      if (cyc == m_tg + mem_lat + 1 && !m_wr) begin
        if (m_own == 1) m_rd_i = ref_mem[m_addr];
        else m_rd_d = ref_mem[m_addr];
      end
      if (cyc == m_tg + mem_lat + 2) m_own = 0;
    end else begin
      gi = i_read;
      gd = d_read | d_write;
      pick = 0;
      if (gi && gd) pick = DPRI ? 2 : (m_last ? 1 : 2);
      else if (gi) pick = 1;
      else if (gd) pick = 2;
      if (pick != 0) begin
        m_own = pick;
        m_tg = cyc;
        m_wr = (pick == 2) && d_write;
        m_addr = (pick == 1) ? i_address : d_address;
        if (pick == 2) m_wdata = d_writedata;
        m_last = (pick == 2);
      end
    end
  endtask

  // strobe recorder for ordering and gap checks
  logic [AW-1:0] grants [$];
  int            rise_q [$];
  int            fall_q [$];
  bit            prev_on = 0;
  bit            had_xfer = 0;
  int            low_run = 0;
  int            min_gap = 99;

  task automatic tick();
    bit son;
    int resp;
    bit on;
    @(posedge CLK);
    cyc++;
    model_step();
    @(negedge CLK);
    son = (m_own != 0) && (cyc <= m_tg + mem_lat);
    resp = (m_own != 0 && cyc == m_tg + mem_lat + 1) ? m_own : 0;
    chk("mem_read", mem_read, son & ~m_wr);
    chk("mem_write", mem_write, son & m_wr);
    chk("mem_address", mem_address, m_addr);
    chk("mem_writedata", mem_writedata, m_wdata);
    chk("i_busywait", i_busywait, i_read & ~RESET & (resp != 1));
    chk("d_busywait", d_busywait,
        (d_read | d_write) & ~RESET & (resp != 2));
    chk("i_readdata", i_readdata, m_rd_i);
    chk("d_readdata", d_readdata, m_rd_d);
    on = mem_read | mem_write;
    if (on && !prev_on) begin
      grants.push_back(mem_address);
      rise_q.push_back(cyc);
      if (had_xfer && low_run < min_gap) min_gap = low_run;
      had_xfer = 1;
      low_run = 0;
    end
    if (!on && prev_on) fall_q.push_back(cyc);
    if (!on) low_run++;
    prev_on = on;
  endtask

  task automatic wait_resp(input bit is_d, input string tag);
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      if (is_d) got = (d_read | d_write) && !d_busywait;
      else got = i_read && !i_busywait;
    end
    chk(tag, got, 1);
  endtask

  task automatic do_reset(input int lat);
    RESET = 1;
    mem_lat = lat;
    tick();
    tick();
    RESET = 0;
  endtask

  function automatic logic [AW-1:0] grant_at(input int k);
    return (grants.size() > k) ? grants[k] : '1;
  endfunction

  initial begin
    logic [DW-1:0] v;
    for (int a = 0; a < 64; a++) begin
      v = $urandom;
      mem_arr[a] = v;
      ref_mem[a] = v;
    end
    mem_arr[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;

    do_reset(5);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_i_readdata", i_readdata, 0);

    // lone icache read, 5-cycle memory
    rise_q.delete(); fall_q.delete();
    i_address = 6'h05;
    i_read = 1;
    wait_resp(0, "t1_resp");
    chk("t1_rdata", i_readdata, 32'hDEADBEEF);
    chk("t1_strobe_len",
        (rise_q.size() == 1 && fall_q.size() == 1)
          ? fall_q[0] - rise_q[0] : -1, 6);
    i_read = 0;
    tick();
    chk("t1_idle_busy", i_busywait, 0);

    // dcache write-back
    d_address = 6'h2A;
    d_writedata = 32'h12345678;
    d_write = 1;
    tick();
    chk("t2_mem_write", mem_write, 1);
    chk("t2_mem_read", mem_read, 0);
    chk("t2_addr", mem_address, 6'h2A);
    chk("t2_wdata", mem_writedata, 32'h12345678);
    wait_resp(1, "t2_resp");
    d_write = 0;
    chk("t2_drd_kept", d_readdata, 0);
    tick();
    tick();

    // simultaneous requests after reset
    do_reset(5);
    grants.delete();
    i_address = 6'h11;
    d_address = 6'h22;
    d_writedata = $urandom;
    i_read = 1;
    d_read = 1;
    if (!DPRI) begin
      wait_resp(0, "t3_resp_i");
      i_read = 0;
      wait_resp(1, "t3_resp_d");
      d_read = 0;
    end else begin
      wait_resp(1, "t3_resp_d");
      d_read = 0;
      wait_resp(0, "t3_resp_i");
      i_read = 0;
    end
    chk("t3_ngrants", grants.size(), 2);
    chk("t3_first", grant_at(0), DPRI ? 6'h22 : 6'h11);
    chk("t3_second", grant_at(1), DPRI ? 6'h11 : 6'h22);
    tick();

    // both held for four transfers
    grants.delete();
    had_xfer = 0;
    min_gap = 99;
    i_address = 6'h01;
    d_address = 6'h02;
    i_read = 1;
    d_read = 1;
    for (int n = 0; n < 100 && grants.size() < 4; n++) tick();
    chk("t4_ngrants", grants.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t4_grant%0d", k), grant_at(k),
          (DPRI || k % 2 == 1) ? 6'h02 : 6'h01);
    chk("t4_gap_ge2", min_gap >= 2, 1);
    i_read = 0;
    d_read = 0;
    for (int n = 0; n < 12; n++) tick();

    // reset two cycles into a dcache read
    do_reset(3);
    d_address = 6'h33;
    d_read = 1;
    tick();
    chk("t5_granted", mem_read, 1);
    tick();
    tick();
    RESET = 1;
    tick();
    chk("t5_mem_read", mem_read, 0);
    chk("t5_d_busy", d_busywait, 0);
    chk("t5_i_busy", i_busywait, 0);
    RESET = 0;
    wait_resp(1, "t5_resp");
    chk("t5_rdata", d_readdata, ref_mem[6'h33]);
    d_read = 0;
    tick();
    tick();

    // icache withdraws mid-transfer, dcache queued behind it
    rise_q.delete(); fall_q.delete();
    i_address = 6'h07;
    i_read = 1;
    tick();
    tick();
    i_read = 0;
    d_address = 6'h3C;
    d_read = 1;
    wait_resp(1, "t6_resp_d");
    chk("t6_i_rdata", i_readdata, ref_mem[6'h07]);
    chk("t6_gap",
        (rise_q.size() == 2 && fall_q.size() >= 1)
          ? rise_q[1] - fall_q[0] : -1, 2);
    d_read = 0;
    tick();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        RESET = 1;
        mem_lat = $urandom_range(1, 6);
      end else begin
        RESET = 0;
      end
      if ($urandom_range(0, 3) == 0) i_read = ~i_read;
      if ($urandom_range(0, 4) == 0) d_read = ~d_read;
      if ($urandom_range(0, 4) == 0) d_write = ~d_write;
      i_address = 6'($urandom);
      d_address = 6'($urandom);
      d_writedata = $urandom;
      tick();
    end
    RESET = 0;
    i_read = 0;
    d_read = 0;
    d_write = 0;
    for (int n = 0; n < 12; n++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares one main-memory port between the instruction cache (read-only) and the data cache (read/write). It sits between both caches' miss interfaces and a single data_memory-style block. It serialises block transfers, holds each requester's busywait high until its transfer completes, and returns read data to the requester that was granted.

Parameters:
ADDR_W, 6, block address width on all ports.
DATA_W, 32, block width on all data buses.

Ports:
CLK  in  1  clock; all state updates on posedge.
RESET  in  1  synchronous, active-high reset.
i_read  in  1  icache block-read request.
i_address  in  ADDR_W  icache block address.
i_readdata  out  DATA_W  block returned to icache.
i_busywait  out  1  icache stall.
d_read  in  1  dcache block-read request.
d_write  in  1  dcache block-write (write-back) request.
d_address  in  ADDR_W  dcache block address.
d_writedata  in  DATA_W  dcache write-back block.
d_readdata  out  DATA_W  block returned to dcache.
d_busywait  out  1  dcache stall.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
mem_address  out  ADDR_W  memory block address.
mem_writedata  out  DATA_W  memory write block.
mem_readdata  in  DATA_W  memory read block.
mem_busywait  in  1  memory busy; asserts combinationally with mem_read/mem_write and falls when the transfer is done.

Behaviour:
- Clock and reset: CLK is the only clock. RESET is synchronous and active-high.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- Reset values: state=IDLE; mem_read=mem_write=0; mem_address=0; mem_writedata=0; i_readdata=d_readdata=0; internal seen_busy=0; last_grant=D. While RESET=1, i_busywait=d_busywait=0.
- Request definitions: req_i = i_read; req_d = d_read|d_write. If d_read and d_write are both high, the request is a write.
- IDLE, at posedge:
  - Only one requester pending: grant it.
  - Both pending: grant the port opposite last_grant (round-robin).
  - On grant: latch address, op and (for D) writedata into the mem_* registers; set last_grant; clear seen_busy; go to BUSY_x.
  - No request: stay in IDLE.
- BUSY_x:
  - mem_read/mem_write are driven from the latched op. They are held constant; requester input changes are ignored.
  - seen_busy is set on any posedge where mem_busywait=1.
  - At a posedge with seen_busy=1 and mem_busywait=0: capture mem_readdata into x_readdata (reads only; writes leave x_readdata unchanged), drop mem_read/mem_write, and go to RESP_x.
- RESP_x: lasts exactly one cycle with x_busywait=0; the next posedge goes to IDLE.
  - Minimum IDLE gap between transfers: 1 cycle.
  - Memory strobes are low for at least 2 cycles between transfers.
- Busywait, combinational:
  - i_busywait = req_i & ~RESET & (state != RESP_I).
  - d_busywait = req_d & ~RESET & (state != RESP_D).
  - A requester is therefore stalled from the same cycle its request rises.
- Latency: a lone request rising before posedge N is granted at N. Memory strobes are high from N. Response cycle = the cycle after memory busywait falls.
- Request withdrawn while waiting (not granted): dropped, no side effects.
- Request withdrawn while BUSY_x: the transfer completes to memory, RESP_x still occurs, and the data is discarded by the requester.
- RESET mid-transfer: the next posedge forces IDLE and all reset values. The in-flight memory strobe is dropped immediately and the memory is expected to be reset alongside.
- Simultaneous new request in the RESP cycle: arbitrated on the following IDLE posedge under normal rules.

Optional Feature:
Macro ARB_DPRIORITY_EN.
- Defined: when both requesters are pending in IDLE, the data port always wins, because a data miss blocks a committed instruction. last_grant is still maintained but unused.
- Undefined: round-robin as above.
- Single-requester behaviour is identical in both builds.

Test Plan:
1. Reset, then i_read=1, i_address=6'h05, with a 5-cycle memory returning 32'hDEADBEEF -> mem_read=1 with mem_address=6'h05 from grant for 6 cycles. i_busywait=1 until the RESP_I cycle, where i_readdata=32'hDEADBEEF and i_busywait=0 for exactly 1 cycle.
2. d_write=1, d_address=6'h2A, d_writedata=32'h12345678 -> mem_write=1, mem_address=6'h2A, mem_writedata=32'h12345678. mem_read stays 0. d_readdata is unchanged after completion.
3. i_read and d_read rise on the same cycle after reset -> I is granted first (last_grant=D), D is granted on the IDLE posedge after RESP_I, and d_busywait stays high throughout. Under ARB_DPRIORITY_EN, D is granted first.
4. Both requesters held continuously for 4 transfers -> grant order I,D,I,D, with the mem_* strobes low for ≥2 cycles between transfers.
5. RESET pulsed for 1 cycle, 2 cycles into a BUSY_D read -> mem_read=0, state IDLE and both busywaits 0 after that posedge. A re-issued d_read then completes normally.
6. i_read dropped one cycle into BUSY_I -> the transfer still completes and RESP_I occurs. A pending d_read is then granted with no lost cycles beyond the 1-cycle IDLE gap.
